// File: rtl/led_frame_scheduler.sv
// Frame scheduler for a 6-pixel GRB strip: shadow/active pixel buffers, periodic frame
// start through the driver load/done handshake, strip latch gap and a send watchdog.
module led_frame_scheduler #(
  parameter int unsigned FRAME_CYCLES   = 800000,
  parameter int unsigned LATCH_CYCLES   = 14400,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned PREP_CYCLES    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         px_we,
  input  logic [2:0]   px_addr,
  input  logic [23:0]  px_data,
  input  logic         commit,
  input  logic         blank,
  input  logic         clr_flags,
  input  logic         drv_done,
  output logic [143:0] drv_rgb,
  output logic         drv_load,
  output logic         drv_rst_leds,
  output logic         busy,
  output logic         frame_sent,
  output logic         pending,
  output logic         err,
  output logic         overrun
);
  localparam int unsigned NUM_PX  = 6;
  localparam int unsigned PX_W    = 24;
  localparam int unsigned RGB_W   = NUM_PX * PX_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_CYCLES);
  localparam int unsigned TMR_MAX =
    (TIMEOUT_CYCLES > LATCH_CYCLES)
      ? ((TIMEOUT_CYCLES > PREP_CYCLES) ? TIMEOUT_CYCLES : PREP_CYCLES)
      : ((LATCH_CYCLES > PREP_CYCLES) ? LATCH_CYCLES : PREP_CYCLES);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_SEND, S_LATCH, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [RGB_W-1:0]   shadow_q, shadow_d;
  logic [RGB_W-1:0]   active_q, active_d;
  logic [RGB_W-1:0]   drv_rgb_q, drv_rgb_d;
  logic               pending_q, pending_d;
  logic               drv_load_q, drv_load_d;
  logic               drv_rst_leds_q, drv_rst_leds_d;
  logic               busy_q, busy_d;
  logic               frame_sent_q, frame_sent_d;
  logic               err_q, err_d;
  logic               overrun_q, overrun_d;
  logic               tick_c, start_c, done_ok_c, timeout_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q          <= '0;
      cnt_q          <= '0;
      tick_q         <= 1'b0;
      shadow_q       <= '0;
      active_q       <= '0;
      drv_rgb_q      <= '0;
      pending_q      <= 1'b0;
      drv_load_q     <= 1'b0;
      drv_rst_leds_q <= 1'b1;
      busy_q         <= 1'b0;
      frame_sent_q   <= 1'b0;
      err_q          <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      tmr_q          <= tmr_d;
      cnt_q          <= cnt_d;
      tick_q         <= tick_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      drv_rgb_q      <= drv_rgb_d;
      pending_q      <= pending_d;
      drv_load_q     <= drv_load_d;
      drv_rst_leds_q <= drv_rst_leds_d;
      busy_q         <= busy_d;
      frame_sent_q   <= frame_sent_d;
      err_q          <= err_d;
      overrun_q      <= overrun_d;
    end
  end

  // Frame tick counter; at most one tick is held until a frame starts
  always_comb begin
    tick_c  = en && (cnt_q == CNT_W'(FRAME_CYCLES - 1));
    start_c = ((state_q == S_IDLE) || (state_q == S_WAIT)) && en && tick_q;
    cnt_d   = cnt_q;
    if (en) cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
    tick_d  = tick_q;
    if (start_c) tick_d = 1'b0;
    if (tick_c)  tick_d = 1'b1;
  end

  // Shadow writes always land; the active copy uses the shadow as it was before this cycle
  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned i = 0; i < NUM_PX; i++) begin
      if (px_we && (px_addr == 3'(i))) shadow_d[(NUM_PX-1-i)*PX_W +: PX_W] = px_data;
    end
    active_d  = active_q;
    pending_d = pending_q;
    if (start_c && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (commit) pending_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = '0;
    done_ok_c = 1'b0;
    timeout_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_c) state_d = S_PREP;
      end
      S_PREP: begin
        if (tmr_q == TMR_W'(PREP_CYCLES - 1)) state_d = S_SEND;
        else                                  tmr_d   = tmr_q + TMR_W'(1);
      end
      S_SEND: begin
        if (drv_done) begin
          done_ok_c = 1'b1;
          state_d   = S_LATCH;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_c = 1'b1;
          state_d   = S_LATCH;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_LATCH: begin
        if (tmr_q == TMR_W'(LATCH_CYCLES - 1)) state_d = S_WAIT;
        else                                   tmr_d   = tmr_q + TMR_W'(1);
      end
      S_WAIT: begin
        if (!en)          state_d = S_IDLE;
        else if (start_c) state_d = S_PREP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs follow the next state; the frame word is captured only at PREP entry
  always_comb begin
    drv_load_d     = (state_d == S_SEND);
    busy_d         = (state_d == S_PREP) || (state_d == S_SEND) || (state_d == S_LATCH);
    frame_sent_d   = done_ok_c;
    drv_rst_leds_d = 1'b0;
    unique case (state_d)
      S_IDLE:  drv_rst_leds_d = 1'b1;
      S_LATCH: drv_rst_leds_d = (state_q == S_SEND) ? timeout_c : drv_rst_leds_q;
      default: drv_rst_leds_d = 1'b0;
    endcase
    drv_rgb_d = drv_rgb_q;
    if (start_c) drv_rgb_d = blank ? '0 : active_d;
    err_d = err_q;
    if (clr_flags) err_d = 1'b0;
    if (timeout_c) err_d = 1'b1;
    overrun_d = overrun_q;
    if (clr_flags)         overrun_d = 1'b0;
    if (tick_c && tick_q)  overrun_d = 1'b1;
  end

  assign drv_rgb      = drv_rgb_q;
  assign drv_load     = drv_load_q;
  assign drv_rst_leds = drv_rst_leds_q;
  assign busy         = busy_q;
  assign frame_sent   = frame_sent_q;
  assign pending      = pending_q;
  assign err          = err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: frame-content scoreboard, driver done model,
// latch/timeout/overrun and reset checks on a shortened frame timing.
module tb_led_frame_scheduler;
  localparam int unsigned FRAME   = 200;
  localparam int unsigned LATCH   = 40;
  localparam int unsigned TIMEOUT = 250;
  localparam int unsigned PREP    = 2;

  logic         clk, rst_n, en, px_we, commit, blank, clr_flags, drv_done;
  logic [2:0]   px_addr;
  logic [23:0]  px_data;
  logic [143:0] drv_rgb;
  logic         drv_load, drv_rst_leds, busy, frame_sent, pending, err, overrun;

  led_frame_scheduler #(
    .FRAME_CYCLES(FRAME), .LATCH_CYCLES(LATCH),
    .TIMEOUT_CYCLES(TIMEOUT), .PREP_CYCLES(PREP)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .px_we(px_we), .px_addr(px_addr),
    .px_data(px_data), .commit(commit), .blank(blank), .clr_flags(clr_flags),
    .drv_done(drv_done), .drv_rgb(drv_rgb), .drv_load(drv_load),
    .drv_rst_leds(drv_rst_leds), .busy(busy), .frame_sent(frame_sent),
    .pending(pending), .err(err), .overrun(overrun)
  );

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           frames = 0;
  int           rise_cyc = 0;
  int           done_edge = 0;
  int           done_lat = 100;
  bit           hold_done = 0;
  bit           have_done = 0;
  bit           sb_on = 0;
  bit           rgb_chk_en = 0;
  logic [143:0] last_exp = '0;
  logic [143:0] sb_q[$];

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [143:0] frame6(input logic [23:0] p0, p1, p2, p3, p4, p5);
    return {p0, p1, p2, p3, p4, p5};
  endfunction

  task automatic wait_frame();
    int target = frames + 1;
    int n = 0;
    while (frames < target && n < 1500) begin
      @(posedge clk);
      n++;
    end
    chk("frame_start", 144'(frames >= target), 144'd1);
  endtask

  task automatic write_px(input logic [2:0] a, input logic [23:0] d);
    @(negedge clk);
    px_we = 1'b1; px_addr = a; px_data = d;
    @(negedge clk);
    px_we = 1'b0;
  endtask

  task automatic pulse_commit();
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard pop on every drv_load rise; also checks the gap since the last done
  initial begin : monitor
    logic load_prev;
    logic [143:0] e;
    load_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (drv_load && !load_prev) begin
        rise_cyc = cyc;
        frames++;
        if (have_done) begin
          chk("latch_gap", 144'((rise_cyc - done_edge) >= int'(LATCH)), 144'd1);
          have_done = 0;
        end
        rgb_chk_en = sb_on;
        if (sb_on) begin
          chk("sb_nonempty", 144'(sb_q.size() != 0), 144'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            last_exp = e;
            chk("drv_rgb", drv_rgb, e);
          end
        end
      end
      load_prev = drv_load;
    end
  end

  // Driver model: done pulse done_lat cycles after load, then handshake checks
  initial begin : drv_model
    int load_cnt;
    int stage;
    load_cnt = 0;
    stage = 0;
    drv_done = 1'b0;
    forever begin
      @(negedge clk);
      if (stage == 2) begin
        chk("fs_pulse_end", 144'(frame_sent), 144'd0);
        stage = 0;
      end
      if (stage == 1) begin
        chk("load_fall", 144'(drv_load), 144'd0);
        chk("frame_sent", 144'(frame_sent), 144'd1);
        if (rgb_chk_en) chk("rgb_stable", drv_rgb, last_exp);
        stage = 2;
      end
      drv_done = 1'b0;
      if (drv_load) load_cnt++;
      else          load_cnt = 0;
      if (drv_load && !hold_done && load_cnt == done_lat) begin
        drv_done  = 1'b1;
        done_edge = cyc + 1;
        have_done = 1;
        stage     = 1;
      end
    end
  end

  initial begin : stim
    int r1, e_edge, n;
    logic [143:0] f1, f2, f3;
    rst_n = 1'b0; en = 1'b0; px_we = 1'b0; px_addr = '0; px_data = '0;
    commit = 1'b0; blank = 1'b0; clr_flags = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", drv_rgb, 144'd0);
    chk("rst_load", 144'(drv_load), 144'd0);
    chk("rst_rst_leds", 144'(drv_rst_leds), 144'd1);
    chk("rst_busy", 144'(busy), 144'd0);
    chk("rst_frame_sent", 144'(frame_sent), 144'd0);
    chk("rst_pending", 144'(pending), 144'd0);
    chk("rst_err", 144'(err), 144'd0);
    chk("rst_overrun", 144'(overrun), 144'd0);
    rst_n = 1'b1;

    // First frame carries px0/px5; address 6 must be dropped
    write_px(3'd0, 24'hFF0000);
    write_px(3'd5, 24'h0000FF);
    write_px(3'd6, 24'hAAAAAA);
    pulse_commit();
    @(negedge clk);
    chk("pending_set", 144'(pending), 144'd1);
    f1 = frame6(24'hFF0000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0000FF);
    sb_on = 1;
    sb_q.push_back(f1);
    en = 1'b1;
    wait_frame();
    chk("pending_clr", 144'(pending), 144'd0);
    chk("busy_send", 144'(busy), 144'd1);
    chk("rst_leds_send", 144'(drv_rst_leds), 144'd0);
    r1 = rise_cyc;

    // Commit and px0 write on the PREP-entry cycle: old shadow used, pending stays
    write_px(3'd1, 24'h123456);
    pulse_commit();
    f2 = frame6(24'hFF0000, 24'h123456, 24'h0, 24'h0, 24'h0, 24'h0000FF);
    sb_q.push_back(f2);
    e_edge = r1 + int'(FRAME) - int'(PREP);
    n = 0;
    @(negedge clk);
    while (cyc != e_edge - 1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    commit = 1'b1; px_we = 1'b1; px_addr = 3'd0; px_data = 24'h00FF00;
    @(negedge clk);
    commit = 1'b0; px_we = 1'b0;
    wait_frame();
    chk("frame_period", 144'(rise_cyc - r1), 144'(FRAME));
    chk("pending_kept", 144'(pending), 144'd1);
    f3 = frame6(24'h00FF00, 24'h123456, 24'h0, 24'h0, 24'h0, 24'h0000FF);
    sb_q.push_back(f3);
    wait_frame();
    chk("pending_used", 144'(pending), 144'd0);

    // Blank frame, then the unchanged active buffer again
    blank = 1'b1;
    sb_q.push_back(144'd0);
    wait_frame();
    blank = 1'b0;
    sb_q.push_back(f3);
    wait_frame();
    sb_on = 0;

    // Frame plus latch longer than the frame period
    done_lat = 190;
    n = 0;
    while (!overrun && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("overrun_set", 144'(overrun), 144'd1);
    chk("no_err_yet", 144'(err), 144'd0);
    wait_frame();

    // Done on the watchdog cycle is a success
    done_lat = int'(TIMEOUT);
    wait_frame();
    chk("done_at_timeout", 144'(err), 144'd0);

    // Watchdog: no done at all
    hold_done = 1;
    n = 0;
    while (!err && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", 144'(cyc - rise_cyc), 144'(TIMEOUT));
    chk("to_rst_leds", 144'(drv_rst_leds), 144'd1);
    chk("to_load_low", 144'(drv_load), 144'd0);
    chk("to_busy", 144'(busy), 144'd1);
    hold_done = 0;
    done_lat = 100;
    wait_frame();
    chk("recover_rst_leds", 144'(drv_rst_leds), 144'd0);
    chk("err_sticky", 144'(err), 144'd1);
    repeat (4) wait_frame();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("err_clr", 144'(err), 144'd0);
    chk("overrun_clr", 144'(overrun), 144'd0);

    // Asynchronous reset in the middle of SEND
    wait_frame();
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_load", 144'(drv_load), 144'd0);
    chk("arst_rst_leds", 144'(drv_rst_leds), 144'd1);
    chk("arst_busy", 144'(busy), 144'd0);
    chk("arst_rgb", drv_rgb, 144'd0);
    chk("sb_drained", 144'(sb_q.size()), 144'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
